// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that shares one combinational ALU
// between the EXE stage (port 0) and an auxiliary unit (port 1).
// One operation is in flight at a time: grant -> execute -> respond.
// The block owns the architectural NZCV register and feeds carry_in to the ALU.
module alu_share_arbiter #(
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      CMD_W    = 4,
  parameter logic [3:0]       STAT_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  // request side
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_val1,
  input  logic [DATA_W-1:0] req0_val2,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req0_s,
  input  logic [DATA_W-1:0] req1_val1,
  input  logic [DATA_W-1:0] req1_val2,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic              req1_s,
  // ALU side
  output logic [DATA_W-1:0] alu_val1,
  output logic [DATA_W-1:0] alu_val2,
  output logic [CMD_W-1:0]  alu_exec_cmd,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_status,
  // response side
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_res,
  output logic [3:0]        resp_status,
  // architectural flags {N,Z,C,V}
  output logic [3:0]        status_reg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q;

  // issued operation (also drives the ALU input ports directly)
  logic [DATA_W-1:0]   alu_val1_q;
  logic [DATA_W-1:0]   alu_val2_q;
  logic [CMD_W-1:0]    alu_cmd_q;
  logic                s_q;
  logic                id_q;

  // arbitration history: port granted most recently
  logic                last_grant_q;

  // response channel and flags
  logic                resp_valid_q;
  logic                resp_id_q;
  logic [DATA_W-1:0]   resp_res_q;
  logic [3:0]          resp_status_q;
  logic [3:0]          status_q;

  // arbitration result for the current cycle
  logic                any_valid;
  logic                grant_id_d;
  logic [DATA_W-1:0]   val1_d;
  logic [DATA_W-1:0]   val2_d;
  logic [CMD_W-1:0]    cmd_d;
  logic                s_d;
  logic                handshake;

  // Pick the winner: sole valid port, or the port not granted last time on a tie
  always_comb begin
    any_valid  = |req_valid;
    grant_id_d = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id_d = ~last_grant_q;
    end else begin
      grant_id_d = req_valid[1];
    end
  end

  // Ready goes to the winner only while idle; at most one bit can be set
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == S_IDLE) && any_valid) begin
      req_ready[grant_id_d] = 1'b1;
    end
  end

  // Operand mux toward the issue registers
  always_comb begin
    val1_d    = grant_id_d ? req1_val1 : req0_val1;
    val2_d    = grant_id_d ? req1_val2 : req0_val2;
    cmd_d     = grant_id_d ? req1_cmd  : req0_cmd;
    s_d       = grant_id_d ? req1_s    : req0_s;
    handshake = |(req_valid & req_ready);
  end

  // Control FSM plus the issue, response and flag registers it owns
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      alu_val1_q    <= '0;
      alu_val2_q    <= '0;
      alu_cmd_q     <= '0;
      s_q           <= 1'b0;
      id_q          <= 1'b0;
      last_grant_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_res_q    <= '0;
      resp_status_q <= '0;
      status_q      <= STAT_RST;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            alu_val1_q   <= val1_d;
            alu_val2_q   <= val2_d;
            alu_cmd_q    <= cmd_d;
            s_q          <= s_d;
            id_q         <= grant_id_d;
            last_grant_q <= grant_id_d;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU settles combinationally within this single cycle
          resp_res_q    <= alu_res;
          resp_status_q <= alu_status;
          resp_id_q     <= id_q;
          resp_valid_q  <= 1'b1;
          if (s_q) begin
            status_q <= alu_status;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          // Response held until taken; the next grant waits one more cycle
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // carry_in only changes at the end of EXEC, so it is stable from grant onward
  assign alu_val1     = alu_val1_q;
  assign alu_val2     = alu_val2_q;
  assign alu_exec_cmd = alu_cmd_q;
  assign alu_carry_in = status_q[1];

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_res     = resp_res_q;
  assign resp_status  = resp_status_q;
  assign status_reg   = status_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                         OP_AND = 4'd4, OP_ORR = 4'd5, OP_EOR = 4'd6, OP_MOV = 4'd7;

  logic          clk, rst;
  logic [1:0]    req_valid, req_ready;
  logic [DW-1:0] req0_val1, req0_val2, req1_val1, req1_val2;
  logic [CW-1:0] req0_cmd, req1_cmd;
  logic          req0_s, req1_s;
  logic [DW-1:0] alu_val1, alu_val2, alu_res;
  logic [CW-1:0] alu_exec_cmd;
  logic          alu_carry_in;
  logic [3:0]    alu_status;
  logic          resp_valid, resp_ready, resp_id;
  logic [DW-1:0] resp_res;
  logic [3:0]    resp_status, status_reg;

  int errs = 0;
  int checks = 0;

  alu_share_arbiter #(.DATA_W(DW), .CMD_W(CW), .STAT_RST(4'b0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_cmd(req0_cmd), .req0_s(req0_s),
    .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_cmd(req1_cmd), .req1_s(req1_s),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_exec_cmd(alu_exec_cmd),
    .alu_carry_in(alu_carry_in), .alu_res(alu_res), .alu_status(alu_status),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_res(resp_res), .resp_status(resp_status), .status_reg(status_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain-arithmetic ALU: returns {N,Z,C,V, result}
  function automatic logic [35:0] alu_fn(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (cmd)
      OP_ADD:  w = {1'b0, a} + {1'b0, b};
      OP_ADC:  w = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      OP_SUB:  w = {1'b0, a} + {1'b0, ~b} + 33'd1;
      OP_SBC:  w = {1'b0, a} + {1'b0, ~b} + {32'b0, cin};
      OP_AND:  w = {1'b0, a & b};
      OP_ORR:  w = {1'b0, a | b};
      OP_EOR:  w = {1'b0, a ^ b};
      default: w = {1'b0, b};
    endcase
    r = w[31:0];
    if (cmd <= OP_SBC) begin
      c = w[32];
      if (cmd == OP_ADD || cmd == OP_ADC) v = (a[31] == b[31]) && (r[31] != a[31]);
      else                                v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Stand-in for the shared combinational ALU
  always_comb {alu_status, alu_res} = alu_fn(alu_exec_cmd, alu_val1, alu_val2, alu_carry_in);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    if (p == 0) begin
      req0_cmd = c; req0_val1 = a; req0_val2 = b; req0_s = s;
    end else begin
      req1_cmd = c; req1_val1 = a; req1_val2 = b; req1_s = s;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    int         port;
    logic [3:0] cmd;
    logic [31:0] a, b;
    logic       s;
    logic [31:0] res;
    logic [3:0] rstat;
    logic [3:0] arch;
    logic       cin;
  } vec_t;

  typedef struct {
    int         id;
    logic [31:0] res;
    logic [3:0] st;
    logic [3:0] arch;
  } exp_t;

  vec_t vecs[8];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t v;
    int   grants[$];
    int   bad_onehot;
    bit   seen;
    // sequential chain of directed ops; each row depends on the flags left by the previous one
    vecs[0] = '{0, OP_ADD, 32'hFFFF_FFF4, 32'd20,        1'b0, 32'd8,         4'b0010, 4'b0000, 1'b0};
    vecs[1] = '{1, OP_ADD, 32'h8000_0001, 32'h8000_0001, 1'b1, 32'h0000_0002, 4'b0011, 4'b0011, 1'b0};
    vecs[2] = '{0, OP_ADC, 32'd0,         32'd0,         1'b0, 32'd1,         4'b0000, 4'b0011, 1'b1};
    vecs[3] = '{1, OP_SUB, 32'd5,         32'd5,         1'b1, 32'd0,         4'b0110, 4'b0110, 1'b1};
    vecs[4] = '{0, OP_SBC, 32'd10,        32'd3,         1'b1, 32'd7,         4'b0010, 4'b0010, 1'b1};
    vecs[5] = '{1, OP_ADD, 32'h7FFF_FFFF, 32'd1,         1'b1, 32'h8000_0000, 4'b1001, 4'b1001, 1'b1};
    vecs[6] = '{0, OP_ADC, 32'd1,         32'd1,         1'b0, 32'd2,         4'b0000, 4'b1001, 1'b0};
    vecs[7] = '{1, OP_EOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 4'b1000, 4'b1000, 1'b0};

    set_req(0, 4'd0, 32'd0, 32'd0, 1'b0);
    set_req(1, 4'd0, 32'd0, 32'd0, 1'b0);
    do_reset();

    // ---- reset state ----
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_id", resp_id, 1'b0);
    chk("rst_resp_res", resp_res, 32'd0);
    chk("rst_resp_status", resp_status, 4'd0);
    chk("rst_alu_val1", alu_val1, 32'd0);
    chk("rst_alu_val2", alu_val2, 32'd0);
    chk("rst_alu_cmd", alu_exec_cmd, 4'd0);
    chk("rst_status_reg", status_reg, 4'd0);
    chk("rst_carry_in", alu_carry_in, 1'b0);

    // ---- directed table: one op at a time ----
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      @(negedge clk);
      set_req(v.port, v.cmd, v.a, v.b, v.s);
      req_valid = (v.port == 0) ? 2'b01 : 2'b10;
      #1;
      chk("vec_req_ready", req_ready, (v.port == 0) ? 2'b01 : 2'b10);
      @(negedge clk);                         // EXEC
      req_valid = 2'b00;
      #1;
      chk("vec_exec_resp_valid", resp_valid, 1'b0);
      chk("vec_exec_req_ready", req_ready, 2'b00);
      chk("vec_alu_val1", alu_val1, v.a);
      chk("vec_alu_val2", alu_val2, v.b);
      chk("vec_alu_cmd", alu_exec_cmd, v.cmd);
      chk("vec_carry_in", alu_carry_in, v.cin);
      @(negedge clk);                         // RESP
      #1;
      chk("vec_resp_valid", resp_valid, 1'b1);
      chk("vec_resp_res", resp_res, v.res);
      chk("vec_resp_id", resp_id, v.port[0]);
      chk("vec_resp_status", resp_status, v.rstat);
      chk("vec_status_reg", status_reg, v.arch);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk("vec_resp_cleared", resp_valid, 1'b0);
      chk("vec_alu_keeps_op", alu_val1, v.a);
    end

    // ---- both ports valid from reset: alternating grants ----
    do_reset();
    set_req(0, OP_ADD, 32'd1, 32'd1, 1'b0);
    set_req(1, OP_ADD, 32'd2, 32'd2, 1'b0);
    req_valid = 2'b11;
    resp_ready = 1'b1;
    bad_onehot = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #1;
      if (req_ready == 2'b11) bad_onehot++;
      if (req_ready == 2'b01) grants.push_back(0);
      if (req_ready == 2'b10) grants.push_back(1);
      @(negedge clk);
    end
    chk("rr_grant_count", grants.size(), 4);
    chk("rr_onehot", bad_onehot, 0);
    for (int g = 0; g < 4; g++) chk("rr_grant_order", (g < grants.size()) ? grants[g] : -1, g % 2);
    req_valid = 2'b00;
    resp_ready = 1'b0;

    // ---- response back-pressure ----
    do_reset();
    set_req(0, OP_ADD, 32'd1, 32'd2, 1'b0);
    set_req(1, OP_ADD, 32'd5, 32'd6, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("bp_first_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = resp_valid;
    end
    chk("bp_resp_arrives", seen, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_res", resp_res, 32'd3);
      chk("bp_hold_id", resp_id, 1'b0);
      chk("bp_hold_status", resp_status, 4'b0000);
      chk("bp_no_ready", req_ready, 2'b00);
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_accept_cycle_no_ready", req_ready, 2'b00);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("bp_resp_cleared", resp_valid, 1'b0);
    chk("bp_next_grant_p1", req_ready, 2'b10);
    req_valid = 2'b00;

    // ---- reset while EXEC after an s=1 grant ----
    do_reset();
    set_req(0, OP_SUB, 32'd3, 32'd5, 1'b1);
    req_valid = 2'b01;
    #1;
    chk("rx_grant", req_ready, 2'b01);
    @(negedge clk);                           // EXEC
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_status_reg", status_reg, 4'b0000);
    chk("rx_alu_val1", alu_val1, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rx_no_resp", resp_valid, 1'b0);
      @(negedge clk);
      #1;
    end
    set_req(1, OP_ADD, 32'd9, 32'd9, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("rx_port0_first", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rx_resp_valid", resp_valid, 1'b1);
    chk("rx_resp_res", resp_res, 32'hFFFF_FFFE);
    chk("rx_status_after", status_reg, 4'b1000);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // ---- randomized run against transaction-level model ----
    do_reset();
    begin
      bit         pend[2];
      logic [3:0] pc[2];
      logic [31:0] pa[2], pb[2];
      logic       ps[2];
      int         m_last;
      logic [3:0] m_stat;
      bit         busy, exp_rv;
      int         age, w;
      logic [1:0] exp_rdy;
      logic [35:0] r;
      exp_t       q[$];
      exp_t       e;
      m_last = 1; m_stat = 4'b0000; busy = 0; age = 0;
      for (int p = 0; p < 2; p++) begin
        pend[p] = 0; pc[p] = '0; pa[p] = '0; pb[p] = '0; ps[p] = 0;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(0, 2) == 0) begin
            pend[p] = 1;
            pc[p] = 4'($urandom_range(0, 7));
            pa[p] = rnd_op();
            pb[p] = rnd_op();
            ps[p] = 1'($urandom_range(0, 1));
          end
          set_req(p, pc[p], pa[p], pb[p], ps[p]);
        end
        req_valid  = {pend[1], pend[0]};
        resp_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (busy) age++;
        exp_rv = busy && (age >= 2);
        chk("rand_resp_valid", resp_valid, exp_rv);
        if (resp_valid && exp_rv && q.size() > 0) begin
          chk("rand_resp_id", resp_id, q[0].id);
          chk("rand_resp_res", resp_res, q[0].res);
          chk("rand_resp_status", resp_status, q[0].st);
          chk("rand_status_reg", status_reg, q[0].arch);
        end
        exp_rdy = 2'b00;
        w = 0;
        if (!busy && (pend[0] || pend[1])) begin
          w = (pend[0] && pend[1]) ? (1 - m_last) : (pend[1] ? 1 : 0);
          exp_rdy = (w == 0) ? 2'b01 : 2'b10;
        end
        chk("rand_req_ready", req_ready, exp_rdy);
        if (exp_rdy != 2'b00) begin
          r = alu_fn(pc[w], pa[w], pb[w], m_stat[1]);
          if (ps[w]) m_stat = r[35:32];
          e = '{w, r[31:0], r[35:32], m_stat};
          q.push_back(e);
          m_last = w;
          busy = 1;
          age = 0;
          pend[w] = 0;
        end else if (exp_rv && resp_ready) begin
          busy = 0;
          if (q.size() > 0) void'(q.pop_front());
        end
        @(negedge clk);
      end
    end
    req_valid = 2'b00;
    resp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
